johnson_counter: RTL and testbench

- Parameterised twisted-ring (Johnson) counter; the default 4-bit instance cycles through 8 states.
- Used as a glitch-free phase/sequence generator and as a teaching and regression block for shift-register applications.
- Provides:
  - a state-index decode, so downstream logic does not re-decode the ring;
  - a wrap pulse;
  - illegal-state detection with self-correction.

---
 rtl/johnson_pkg.sv | 54 +++++
 rtl/johnson_decode.sv | 23 ++
 rtl/johnson_counter.sv | 78 +++++++
 tb/tb_johnson_counter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// johnson_pkg
//   Shared definitions for the Johnson (twisted-ring) counter.
//   jc_legal(q, w) : 1 when the low w bits of q form one of the 2*w legal
//                    ring codes (at most one 0/1 boundary between neighbours).
//   jc_index(q, w) : position of a legal code in the forward sequence,
//                    0 for an illegal code.
//   Both take the code zero-extended to JC_MAX_W bits plus the live width,
//   so one function body serves every instance width up to JC_MAX_W.
package johnson_pkg;

    localparam int JC_MAX_W = 32;
    localparam int JC_IDX_W = $clog2(2 * JC_MAX_W);

    // What the ring register does at the next rising edge.
    typedef enum logic [1:0] {
        JC_HOLD  = 2'd0,
        JC_CLEAR = 2'd1,
        JC_FIX   = 2'd2,
        JC_STEP  = 2'd3
    } jc_action_e;

    // Legal codes are 0..01..1 and 1..10..0, i.e. exactly the patterns with
    // no more than one place where adjacent bits differ.
    function automatic logic jc_legal(input logic [JC_MAX_W-1:0] q, input int w);
        int edges;
        edges = 0;
        for (int i = 0; i < JC_MAX_W - 1; i++) begin
            if ((i < w - 1) && (q[i] != q[i+1])) begin
                edges = edges + 1;
            end
        end
        return (edges <= 1);
    endfunction

    // With MSB clear the code has k low ones -> index k. With MSB set the
    // code is all-ones followed by j low zeros -> index w+j = 2w-popcount.
    function automatic logic [JC_IDX_W-1:0] jc_index(input logic [JC_MAX_W-1:0] q, input int w);
        int ones;
        ones = 0;
        for (int i = 0; i < JC_MAX_W; i++) begin
            if (i < w) begin
                ones = ones + int'(q[i]);
            end
        end
        if (!jc_legal(q, w)) begin
            return '0;
        end
        if (q[w-1] == 1'b0) begin
            return JC_IDX_W'(ones);
        end
        return JC_IDX_W'(2 * w - ones);
    endfunction

endpackage

// File: rtl/johnson_decode.sv
// johnson_decode
//   Combinational decode of the ring contents.
//   Ports:
//     q       in  WIDTH  ring register contents
//     idx     out IDXW   sequence position of q (0 for an illegal code)
//     illegal out 1      q is not one of the 2*WIDTH legal codes
module johnson_decode
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int IDXW = $clog2(2 * WIDTH)
) (
    input  logic [WIDTH-1:0] q,
    output logic [IDXW-1:0]  idx,
    output logic             illegal
);

    always_comb begin
        idx     = IDXW'(jc_index(JC_MAX_W'(q), WIDTH));
        illegal = ~jc_legal(JC_MAX_W'(q), WIDTH);
    end

endmodule

// File: rtl/johnson_counter.sv
// johnson_counter
//   Parameterised twisted-ring counter, 2*WIDTH states, with index decode,
//   boundary (wrap) pulse and one-cycle recovery from illegal codes.
//   Ports:
//     clk     in  1      rising-edge clock
//     reset   in  1      asynchronous reset, active low (q -> 0)
//     en      in  1      count enable (hold when 0)
//     up      in  1      1 = forward shift, 0 = reverse shift
//     clr     in  1      synchronous clear, beats illegal fix and en
//     q       out WIDTH  ring register
//     idx     out IDXW   position of q in the sequence
//     wrap    out 1      next edge crosses the sequence boundary
//     illegal out 1      q holds a non-ring code
module johnson_counter
    import johnson_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int IDXW = $clog2(2 * WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    output logic [WIDTH-1:0] q,
    output logic [IDXW-1:0]  idx,
    output logic             wrap,
    output logic             illegal
);

    logic [WIDTH-1:0] q_r;
    jc_action_e       action;

    johnson_decode #(.WIDTH(WIDTH)) u_decode (
        .q       (q_r),
        .idx     (idx),
        .illegal (illegal)
    );

    // Priority: clear, then illegal-code repair (independent of en), then count.
    always_comb begin
        action = JC_HOLD;
        if (clr) begin
            action = JC_CLEAR;
        end else if (illegal) begin
            action = JC_FIX;
        end else if (en) begin
            action = JC_STEP;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r <= '0;
        end else begin
            case (action)
                JC_CLEAR, JC_FIX: q_r <= '0;
                JC_STEP: begin
                    if (up) begin
                        q_r <= {q_r[WIDTH-2:0], ~q_r[WIDTH-1]};
                    end else begin
                        q_r <= {~q_r[0], q_r[WIDTH-1:1]};
                    end
                end
                default: q_r <= q_r;
            endcase
        end
    end

    // Forward wraps out of the last index, reverse wraps out of index 0.
    always_comb begin
        wrap = (action == JC_STEP) &&
               (up ? (idx == IDXW'(2 * WIDTH - 1)) : (idx == '0));
    end

    assign q = q_r;

endmodule

// File: tb/tb_johnson_counter.sv
// tb_johnson_counter
//   Directed bench for the default 4-bit johnson_counter.
module tb_johnson_counter;
    import johnson_pkg::*;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up;
    logic       clr;
    logic [3:0] q;
    logic [2:0] idx;
    logic       wrap;
    logic       illegal;

    int checks;
    int failures;

    johnson_counter #(.WIDTH(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .up      (up),
        .clr     (clr),
        .q       (q),
        .idx     (idx),
        .wrap    (wrap),
        .illegal (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] fwd_q   [8];
    logic [2:0] fwd_idx [8];
    logic [3:0] rev_q   [8];
    logic [2:0] rev_idx [8];

    initial begin
        fwd_q   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        fwd_idx = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        rev_q   = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        rev_idx = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        checks   = 0;
        failures = 0;

        // Reset state
        reset = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0;
        #2;
        check("rst_q", 32'(q), 32'h0);
        check("rst_idx", 32'(idx), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        check("rst_wrap", 32'(wrap), 32'h0);
        #8;
        reset = 1'b1; en = 1'b1; up = 1'b1;

        // Forward count, two full laps; wrap is high while q=1000
        for (int i = 0; i < 16; i++) begin
            step();
            check("fwd_q", 32'(q), 32'(fwd_q[i % 8]));
            check("fwd_idx", 32'(idx), 32'(fwd_idx[i % 8]));
            check("fwd_wrap", 32'(wrap), 32'(fwd_q[i % 8] == 4'b1000));
        end

        // Reverse from 0000; wrap high at 0000 before the first step
        up = 1'b0;
        #1;
        check("rev_wrap0", 32'(wrap), 32'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("rev_q", 32'(q), 32'(rev_q[i]));
            check("rev_idx", 32'(idx), 32'(rev_idx[i]));
            check("rev_wrap", 32'(wrap), 32'(rev_q[i] == 4'b0000));
        end

        // Hold then clear
        up = 1'b1;
        step(); step(); step();
        check("cnt_0111", 32'(q), 32'h7);
        en = 1'b0;
        #1;
        check("hold_wrap", 32'(wrap), 32'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_q", 32'(q), 32'h7);
        end
        clr = 1'b1; en = 1'b1;
        #1;
        check("clr_wrap", 32'(wrap), 32'h0);
        step();
        check("clr_q", 32'(q), 32'h0);
        clr = 1'b0;

        // Direction flip at 0011
        up = 1'b1;
        step(); step();
        check("flip_pre", 32'(q), 32'h3);
        up = 1'b0;
        step();
        check("flip_q1", 32'(q), 32'h1);
        step();
        check("flip_q2", 32'(q), 32'h0);

        // Decode sweep against the package reference model
        en = 1'b0;
        for (int v = 0; v < 16; v++) begin
            force dut.q_r = 4'(v);
            #1;
            check("sweep_idx", 32'(idx), 32'(jc_index(JC_MAX_W'(v), 4)));
            check("sweep_illegal", 32'(illegal), 32'(!jc_legal(JC_MAX_W'(v), 4)));
        end
        release dut.q_r;

        // Illegal-code recovery with en=0
        @(negedge clk);
        force dut.q_r = 4'b0101;
        #1;
        check("ill_flag", 32'(illegal), 32'h1);
        check("ill_idx", 32'(idx), 32'h0);
        check("ill_wrap", 32'(wrap), 32'h0);
        release dut.q_r;
        step();
        check("ill_fix_q", 32'(q), 32'h0);
        check("ill_fix_flag", 32'(illegal), 32'h0);

        // Asynchronous reset mid-count at q=1110
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("pre_areset", 32'(q), 32'he);
        #2;
        reset = 1'b0;
        #1;
        check("areset_q", 32'(q), 32'h0);
        check("areset_idx", 32'(idx), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check("post_areset", 32'(q), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
